// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and outstanding mul/div stall control with stall counters
module hazard_scoreboard #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ID_VALID,
  input  logic [4:0]           ID_RS1,
  input  logic [4:0]           ID_RS2,
  input  logic [4:0]           ID_RD,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic                 ID_REG_WRITE,
  input  logic                 ID_IS_MULDIV,
  input  logic                 ID_EX_MEM_READ,
  input  logic [4:0]           ID_EX_RD,
  input  logic                 FLUSH,
  input  logic                 MD_DONE,
  output logic                 STALL,
  output logic                 BUBBLE,
  output logic                 MD_START,
  output logic                 MD_BUSY,
  output logic [4:0]           MD_PEND_RD,
  output logic [CNT_WIDTH-1:0] LOADUSE_CNT,
  output logic [CNT_WIDTH-1:0] MULDIV_CNT
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state_q, state_d;
  logic [4:0]           pend_rd_q, pend_rd_d;
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d, md_cnt_q, md_cnt_d;
  logic                 md_start_q, md_start_d;
  logic                 load_use, md_hazard, issue;
  always_comb begin
    load_use = ID_VALID & ID_EX_MEM_READ & (ID_EX_RD != 5'd0) &
               ((ID_USES_RS1 & (ID_RS1 == ID_EX_RD)) | (ID_USES_RS2 & (ID_RS2 == ID_EX_RD)));
    md_hazard = ID_VALID & (state_q == BUSY) & (ID_IS_MULDIV | ((pend_rd_q != 5'd0) &
                ((ID_USES_RS1 & (ID_RS1 == pend_rd_q)) | (ID_USES_RS2 & (ID_RS2 == pend_rd_q)) |
                 (ID_REG_WRITE & (ID_RD == pend_rd_q)))));
    STALL = (load_use | md_hazard) & ~FLUSH & ~rst;
    BUBBLE = STALL;
    issue = ID_VALID & ID_IS_MULDIV & ~STALL & ~FLUSH & (state_q == IDLE);
    state_d = issue ? BUSY : (MD_DONE ? IDLE : state_q);
    pend_rd_d = issue ? ID_RD : ((state_q == BUSY) & MD_DONE ? 5'd0 : pend_rd_q);
    md_start_d = issue;
    lu_cnt_d = lu_cnt_q + CNT_WIDTH'(STALL & load_use);
    md_cnt_d = md_cnt_q + CNT_WIDTH'(STALL & ~load_use & md_hazard);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= 5'd0;
      lu_cnt_q   <= '0;
      md_cnt_q   <= '0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      lu_cnt_q   <= lu_cnt_d;
      md_cnt_q   <= md_cnt_d;
      md_start_q <= md_start_d;
    end
  end
  assign MD_START    = md_start_q;
  assign MD_BUSY     = (state_q == BUSY);
  assign MD_PEND_RD  = pend_rd_q;
  assign LOADUSE_CNT = lu_cnt_q;
  assign MULDIV_CNT  = md_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scenario tasks with a queue of expected post-edge state
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_muldiv;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ex_rd;
  logic        id_ex_mem_read, flush, md_done;
  logic        stall, bubble, md_start, md_busy;
  logic [4:0]  md_pend_rd;
  logic [31:0] loaduse_cnt, muldiv_cnt;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_lu = 0;
  logic [31:0] exp_md = 0;
  typedef struct {
    string       name;
    logic        busy;
    logic [4:0]  pend;
    logic        start;
    logic [31:0] lu;
    logic [31:0] md;
  } exp_t;
  exp_t exp_q[$];
  hazard_scoreboard #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ID_VALID(id_valid), .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RD(id_rd),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .ID_REG_WRITE(id_reg_write),
    .ID_IS_MULDIV(id_is_muldiv), .ID_EX_MEM_READ(id_ex_mem_read), .ID_EX_RD(id_ex_rd),
    .FLUSH(flush), .MD_DONE(md_done),
    .STALL(stall), .BUBBLE(bubble), .MD_START(md_start), .MD_BUSY(md_busy),
    .MD_PEND_RD(md_pend_rd), .LOADUSE_CNT(loaduse_cnt), .MULDIV_CNT(muldiv_cnt)
  );
  always #5 clk = ~clk;
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic w, input logic md);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = w; id_is_muldiv = md;
  endtask
  task automatic set_ex(input logic load, input logic [4:0] rd);
    id_ex_mem_read = load; id_ex_rd = rd;
  endtask
  task automatic cycle(input string name, input logic es, input logic lu_inc, input logic md_inc,
                       input logic eb, input logic [4:0] ep, input logic est);
    exp_t e;
    #1;
    checks++;
    if (stall !== es) begin failures++; $display("FAIL %s stall got=%b exp=%b", name, stall, es); end
    checks++;
    if (bubble !== es) begin failures++; $display("FAIL %s bubble got=%b exp=%b", name, bubble, es); end
    exp_lu = rst ? 32'd0 : exp_lu + 32'(lu_inc);
    exp_md = rst ? 32'd0 : exp_md + 32'(md_inc);
    e.name = name; e.busy = eb; e.pend = ep; e.start = est; e.lu = exp_lu; e.md = exp_md;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (md_busy !== e.busy) begin failures++; $display("FAIL %s md_busy got=%b exp=%b", e.name, md_busy, e.busy); end
    checks++;
    if (md_pend_rd !== e.pend) begin failures++; $display("FAIL %s md_pend_rd got=%0d exp=%0d", e.name, md_pend_rd, e.pend); end
    checks++;
    if (md_start !== e.start) begin failures++; $display("FAIL %s md_start got=%b exp=%b", e.name, md_start, e.start); end
    checks++;
    if (loaduse_cnt !== e.lu) begin failures++; $display("FAIL %s loaduse_cnt got=%0d exp=%0d", e.name, loaduse_cnt, e.lu); end
    checks++;
    if (muldiv_cnt !== e.md) begin failures++; $display("FAIL %s muldiv_cnt got=%0d exp=%0d", e.name, muldiv_cnt, e.md); end
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    set_ex(1'b1, 5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    set_ex(1'b0, 5'd0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic test_load_use;
    set_ex(1'b1, 5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    cycle("lu_stall", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b0, 5'd0);
    cycle("lu_release", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b1, 5'd0);
    set_id(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    cycle("lu_x0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b1, 5'd9);
    set_id(1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 5'd6, 1'b1, 1'b0);
    cycle("lu_rs2_unused", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    id_uses_rs2 = 1'b1;
    cycle("lu_rs2", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b0, 5'd0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic test_muldiv_raw;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    cycle("raw_issue", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
    set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
    cycle("raw_stall1", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    cycle("raw_stall2", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    md_done = 1'b1;
    cycle("raw_done", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
    cycle("raw_release", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask
  task automatic test_back_to_back;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1);
    cycle("b2b_issue1", 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("b2b_done1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b1);
    cycle("b2b_issue2", 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("b2b_done2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
  endtask
  task automatic test_struct_waw;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    cycle("sw_issue", 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1);
    cycle("sw_struct", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    cycle("sw_waw", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    cycle("sw_indep", 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("sw_done", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
  endtask
  task automatic test_rd_x0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
    cycle("x0_issue", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    cycle("x0_no_raw", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
    cycle("x0_struct", 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("x0_done", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
  endtask
  task automatic test_flush;
    set_ex(1'b1, 5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    cycle("flush_lu", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b0, 5'd0);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    cycle("flush_md", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic test_simultaneous;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
    cycle("sim_issue", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    set_ex(1'b1, 5'd5);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    cycle("sim_both", 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    set_ex(1'b0, 5'd0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("sim_done", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
  endtask
  task automatic test_reset_mid;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
    cycle("rm_issue", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
    set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
    cycle("rm_stall", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    rst = 1'b1;
    cycle("rm_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    cycle("rm_after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    md_done = 1'b1;
    cycle("rm_late_done", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    md_done = 1'b0;
    cycle("rm_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    md_done = 1'b0;
    set_ex(1'b0, 5'd0);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_muldiv_raw();
    test_back_to_back();
    test_struct_waw();
    test_rd_x0();
    test_flush();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
